core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle control FSM for the RV32I core datapath (ALU, register file, decode unit).
- Sequences fetch, decode, execute, memory and writeback with req/ack handshakes to instruction and data memory.
- Owns the PC, the instruction register and the retired-instruction counter.
- Gates register-file writes and memory requests from the decode unit's control bits.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 255, memory-ack wait limit (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid same cycle
imem_rdata  in  32  fetched instruction
ir  out  32  instruction register, feeds decode unit and register-file rs1/rs2/rd
imm  in  32  sign-extended immediate from immediate generator
cu_mem_to_reg  in  1  decode: writeback selects memory data
cu_mem_wr  in  1  decode: store
cu_branch  in  1  decode: branch
alu_result  in  32  ALU Result
rs2_data  in  32  register-file R2
dmem_req  out  1  data memory request
dmem_we  out  1  data write (store)
dmem_addr  out  32  data address
dmem_wdata  out  32  store data
dmem_ack  in  1  data access complete; dmem_rdata valid same cycle
dmem_rdata  in  32  load data
rf_we  out  1  register-file writeEnable
rf_wdata  out  32  register-file wd
pc  out  32  program counter
retired  out  32  retired-instruction count
halted  out  1  core stopped
illegal  out  1  halt cause: unsupported opcode
bus_err  out  1  halt cause: memory timeout (0 unless feature enabled)

Behaviour:
- Reset (rst==0 at posedge):
  - state=FETCH, pc=RESET_PC, ir=0, retired=0, alu_q=0, mem_q=0.
  - halted, illegal and bus_err = 0.
  - Reset overrides any in-flight request; any pending ack is ignored.
- Outputs are Moore-decoded from state:
  - imem_req=1 only in FETCH.
  - dmem_req=1 only in MEM.
  - rf_we=1 only in WB.
  - All outputs are 0 otherwise.
- imem_addr=pc.
- dmem_addr=alu_q.
- dmem_wdata=rs2_data, stable from DECODE on.
- dmem_we=cu_mem_wr while in MEM.
- FETCH:
  - Held until posedge with imem_ack=1; at that edge ir<=imem_rdata, then DECODE.
  - ack outside FETCH is ignored.
- DECODE (1 cycle):
  - opcode = ir[6:0].
  - 0110011, 0010011, 0000011, 0100011, 1100011 -> EXEC.
  - 1110011 -> HALT with halted=1.
  - Any other opcode -> HALT with halted=1 and illegal=1.
- EXEC (1 cycle):
  - alu_q<=alu_result.
  - Branch: pc<=pc+imm if alu_result[0]==1, else pc+4; retired++; then FETCH.
  - Load or store -> MEM.
  - Otherwise -> WB.
- MEM:
  - Held until dmem_ack.
  - Load: mem_q<=dmem_rdata, then WB.
  - Store: pc<=pc+4, retired++, then FETCH.
- WB (1 cycle):
  - rf_wdata = cu_mem_to_reg ? mem_q : alu_q.
  - rf_we pulses even when rd=0 (register file forces x0).
  - pc<=pc+4, retired++, then FETCH.
- HALT: absorbing; only reset exits. No requests issued, pc frozen.
- Arithmetic:
  - pc math is modulo 2^32; wrap from 32'hFFFF_FFFC+4 -> 0 is legal.
  - retired wraps 32'hFFFF_FFFF -> 0.
- Latency with zero-wait ack (ack in first request cycle):
  - ALU op: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles

Optional Feature:
SEQ_MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit wait counter clears on entry to FETCH/MEM and increments each cycle the request is unacknowledged.
  - On reaching TIMEOUT_CYCLES with no ack: HALT, halted=1, bus_err=1, request dropped the next cycle.
  - An ack on the same edge as the limit wins; no error.
- Undefined: waits indefinitely; bus_err tied 0; no counter logic.

Decomposition:
- Shared package core_pkg holds:
  - state enum {FETCH, DECODE, EXEC, MEM, WB, HALT}
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM
  - RESET_PC default
- Sub-module mem_wait_timer (feature-only counter) is the natural split; everything else is one FSM module.

Test Plan:
- Reset then `addi x1,x0,5` (32'h00500093) with zero-wait imem -> pc 0->4 after 4 cycles; rf_we pulses once with rf_wdata=5; retired=1.
- Load with dmem_ack delayed 3 cycles -> dmem_req held 3 cycles then drops; WB rf_wdata=dmem_rdata; pc+4; total latency 8.
- Branch taken (alu_result=1, imm=-8) at pc=16 -> pc=8, no rf_we, no dmem_req; not-taken (alu_result=0) -> pc=20.
- ir=32'h00000073 (ecall) -> halted=1, illegal=0, imem_req stays 0; ir=32'h0000007F -> halted=1, illegal=1.
- rst=0 asserted mid-MEM with dmem_req high -> next cycle dmem_req=0, pc=RESET_PC, retired=0; a late dmem_ack has no effect.
- With SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, imem_ack never asserted -> bus_err=1 and halted=1 after 4 cycles. Without the macro -> imem_req stays high indefinitely.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding, opcodes and reset PC for the core sequencer
// Contents: state_t (FETCH..HALT), RV32I major opcodes, CORE_RESET_PC,
//           is_exec_op() which tells DECODE whether an opcode continues to EXEC.
package core_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

   function automatic logic is_exec_op(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - instruction and data memory req/ack buses of the core sequencer
// imem: imem_req, imem_addr (to memory); imem_ack, imem_rdata (from memory)
// dmem: dmem_req, dmem_we, dmem_addr, dmem_wdata (to memory); dmem_ack, dmem_rdata (from memory)
// master = sequencer side, slave = memory side.
interface core_sequencer_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unacknowledged request cycles and flags a memory timeout
// Ports: clk, rst (sync, active-low); waiting = a request is outstanding;
//        ack = the matching acknowledge; expired = this edge is the LIMIT-th unacked cycle.
module mem_wait_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   input  logic ack,
   output logic expired
);

   localparam int            CW   = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt;

   // Leaving a wait state always needs an ack (or a timeout into HALT), so
   // clearing on ack or when idle gives a fresh count on every FETCH/MEM entry.
   always_ff @(posedge clk) begin
      if (!rst || !waiting || ack) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // An ack arriving on the limit edge takes priority over the timeout.
   assign expired = waiting & ~ack & (cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the RV32I core
// Ports: clk, rst (sync, active-low); mem (core_sequencer_if.master: imem/dmem req/ack buses);
//        ir out; imm, cu_mem_to_reg, cu_mem_wr, cu_branch, alu_result, rs2_data in;
//        rf_we, rf_wdata, pc, retired, halted, illegal, bus_err out.
// Optional macro SEQ_MEM_TIMEOUT_EN: halt with bus_err after TIMEOUT_CYCLES unacked memory cycles.
module core_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = CORE_RESET_PC,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   core_sequencer_if.master        mem,
   output logic [31:0]             ir,
   input  logic [31:0]             imm,
   input  logic                    cu_mem_to_reg,
   input  logic                    cu_mem_wr,
   input  logic                    cu_branch,
   input  logic [31:0]             alu_result,
   input  logic [31:0]             rs2_data,
   output logic                    rf_we,
   output logic [31:0]             rf_wdata,
   output logic [31:0]             pc,
   output logic [31:0]             retired,
   output logic                    halted,
   output logic                    illegal,
   output logic                    bus_err
);

   state_t      state;
   logic [31:0] alu_q;
   logic [31:0] mem_q;
   logic        imem_req_q;
   logic        dmem_req_q;
   logic        bus_err_q;
   logic        timeout;

`ifdef SEQ_MEM_TIMEOUT_EN
   // Only one of the two requests is ever outstanding, so a single timer serves both.
   mem_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .waiting (imem_req_q | dmem_req_q),
      .ack     (imem_req_q ? mem.imem_ack : mem.dmem_ack),
      .expired (timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   assign mem.imem_req   = imem_req_q;
   assign mem.imem_addr  = pc;
   assign mem.dmem_req   = dmem_req_q;
   assign mem.dmem_we    = dmem_req_q & cu_mem_wr;
   assign mem.dmem_addr  = alu_q;
   assign mem.dmem_wdata = rs2_data;
   assign rf_wdata       = rf_we ? (cu_mem_to_reg ? mem_q : alu_q) : 32'h0;
   assign bus_err        = bus_err_q;

   // Request/write-enable flags are registered alongside the state so each
   // one is high exactly while the FSM sits in its owning state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         ir         <= 32'h0;
         retired    <= 32'h0;
         alu_q      <= 32'h0;
         mem_q      <= 32'h0;
         imem_req_q <= 1'b1;
         dmem_req_q <= 1'b0;
         rf_we      <= 1'b0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (mem.imem_ack) begin
                  ir         <= mem.imem_rdata;
                  imem_req_q <= 1'b0;
                  state      <= DECODE;
               end else if (timeout) begin
                  imem_req_q <= 1'b0;
                  halted     <= 1'b1;
                  bus_err_q  <= 1'b1;
                  state      <= HALT;
               end
            end
            DECODE: begin
               if (is_exec_op(ir[6:0])) begin
                  state <= EXEC;
               end else begin
                  halted  <= 1'b1;
                  illegal <= (ir[6:0] != OP_SYSTEM);
                  state   <= HALT;
               end
            end
            EXEC: begin
               alu_q <= alu_result;
               if (cu_branch) begin
                  pc         <= alu_result[0] ? pc + imm : pc + 32'd4;
                  retired    <= retired + 32'd1;
                  imem_req_q <= 1'b1;
                  state      <= FETCH;
               end else if (cu_mem_to_reg || cu_mem_wr) begin
                  dmem_req_q <= 1'b1;
                  state      <= MEM;
               end else begin
                  rf_we <= 1'b1;
                  state <= WB;
               end
            end
            MEM: begin
               if (mem.dmem_ack) begin
                  dmem_req_q <= 1'b0;
                  if (cu_mem_wr) begin
                     pc         <= pc + 32'd4;
                     retired    <= retired + 32'd1;
                     imem_req_q <= 1'b1;
                     state      <= FETCH;
                  end else begin
                     mem_q <= mem.dmem_rdata;
                     rf_we <= 1'b1;
                     state <= WB;
                  end
               end else if (timeout) begin
                  dmem_req_q <= 1'b0;
                  halted     <= 1'b1;
                  bus_err_q  <= 1'b1;
                  state      <= HALT;
               end
            end
            WB: begin
               rf_we      <= 1'b0;
               pc         <= pc + 32'd4;
               retired    <= retired + 32'd1;
               imem_req_q <= 1'b1;
               state      <= FETCH;
            end
            default: begin
               // HALT is absorbing; only reset leaves it.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer against an instruction-level model
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ir, imm, alu_result, rs2_data, rf_wdata, pc, retired;
   logic        cu_mem_to_reg, cu_mem_wr, cu_branch, rf_we, halted, illegal, bus_err;

   core_sequencer_if bus();

   core_sequencer #(
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem           (bus),
      .ir            (ir),
      .imm           (imm),
      .cu_mem_to_reg (cu_mem_to_reg),
      .cu_mem_wr     (cu_mem_wr),
      .cu_branch     (cu_branch),
      .alu_result    (alu_result),
      .rs2_data      (rs2_data),
      .rf_we         (rf_we),
      .rf_wdata      (rf_wdata),
      .pc            (pc),
      .retired       (retired),
      .halted        (halted),
      .illegal       (illegal),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   // Decode-unit stand-in: control bits straight from the opcode in ir.
   assign cu_mem_to_reg = (ir[6:0] == 7'b0000011);
   assign cu_mem_wr     = (ir[6:0] == 7'b0100011);
   assign cu_branch     = (ir[6:0] == 7'b1100011);

   typedef struct packed {
      logic        imem_ack;
      logic [31:0] imem_rdata;
      logic        dmem_ack;
      logic [31:0] dmem_rdata;
      logic [31:0] alu_result;
      logic [31:0] imm;
      logic [31:0] rs2_data;
      logic        e_imem_req;
      logic [31:0] e_pc;
      logic        e_dmem_req;
      logic        e_dmem_we;
      logic [31:0] e_dmem_addr;
      logic [31:0] e_dmem_wdata;
      logic        e_rf_we;
      logic [31:0] e_rf_wdata;
      logic [31:0] e_retired;
      logic [31:0] e_ir;
      logic        e_halted;
      logic        e_illegal;
   } cyc_t;

   cyc_t        q[$];
   logic [31:0] m_pc, m_ret, m_ir;
   logic        m_halted, m_illegal;
   int          n_chk = 0;
   int          n_fail = 0;
   int          rf_we_cnt = 0;
   logic [31:0] last_wdata = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic cyc_t base();
      cyc_t r;
      r            = '0;
      r.imem_rdata = $urandom;
      r.dmem_rdata = $urandom;
      r.alu_result = $urandom;
      r.imm        = $urandom;
      r.rs2_data   = $urandom;
      r.e_pc       = m_pc;
      r.e_retired  = m_ret;
      r.e_ir       = m_ir;
      r.e_halted   = m_halted;
      r.e_illegal  = m_illegal;
      return r;
   endfunction

   // Cycle in which stray acks must be ignored.
   function automatic cyc_t noisy(input logic [31:0] rs2);
      cyc_t r;
      r          = base();
      r.imem_ack = 1'($urandom_range(0, 1));
      r.dmem_ack = 1'($urandom_range(0, 1));
      r.rs2_data = rs2;
      return r;
   endfunction

   // Appends the expected cycle trace of one instruction, built from the
   // per-class step sequence and the chosen memory wait counts.
   task automatic gen(input logic [31:0] word, input int fw, input int mk,
                      input logic [31:0] alu, input logic [31:0] immv,
                      input logic [31:0] rdata, input logic [31:0] rs2, output int ncyc);
      cyc_t       r;
      logic [6:0] op;
      int         start;
      start = q.size();
      op    = word[6:0];
      for (int i = 0; i <= fw; i++) begin
         r            = base();
         r.e_imem_req = 1'b1;
         r.dmem_ack   = 1'($urandom_range(0, 1));
         if (i == fw) begin
            r.imem_ack   = 1'b1;
            r.imem_rdata = word;
         end
         q.push_back(r);
      end
      m_ir = word;
      q.push_back(noisy(rs2));
      if (!(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011})) begin
         m_halted  = 1'b1;
         m_illegal = (op != 7'b1110011);
         for (int i = 0; i < 3; i++) q.push_back(noisy(rs2));
      end else begin
         r            = noisy(rs2);
         r.alu_result = alu;
         r.imm        = immv;
         q.push_back(r);
         if (op == 7'b1100011) begin
            m_pc  = alu[0] ? m_pc + immv : m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
         end else if (op == 7'b0000011 || op == 7'b0100011) begin
            for (int i = 0; i <= mk; i++) begin
               r              = base();
               r.imem_ack     = 1'($urandom_range(0, 1));
               r.rs2_data     = rs2;
               r.e_dmem_req   = 1'b1;
               r.e_dmem_we    = (op == 7'b0100011);
               r.e_dmem_addr  = alu;
               r.e_dmem_wdata = rs2;
               if (i == mk) begin
                  r.dmem_ack   = 1'b1;
                  r.dmem_rdata = rdata;
               end
               q.push_back(r);
            end
            if (op == 7'b0100011) begin
               m_pc  = m_pc + 32'd4;
               m_ret = m_ret + 32'd1;
            end else begin
               r            = noisy(rs2);
               r.e_rf_we    = 1'b1;
               r.e_rf_wdata = rdata;
               q.push_back(r);
               m_pc  = m_pc + 32'd4;
               m_ret = m_ret + 32'd1;
            end
         end else begin
            r            = noisy(rs2);
            r.e_rf_we    = 1'b1;
            r.e_rf_wdata = alu;
            q.push_back(r);
            m_pc  = m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
         end
      end
      ncyc = q.size() - start;
   endtask

   task automatic gen_rand_alu();
      logic [31:0] w;
      int          n;
      w      = $urandom;
      w[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011;
      gen(w, $urandom_range(0, 2), 0, $urandom, $urandom, $urandom, $urandom, n);
   endtask

   task automatic gen_rand();
      logic [31:0] w;
      int          n;
      w = $urandom;
      case ($urandom_range(0, 4))
         0:       w[6:0] = 7'b0110011;
         1:       w[6:0] = 7'b0010011;
         2:       w[6:0] = 7'b0000011;
         3:       w[6:0] = 7'b0100011;
         default: w[6:0] = 7'b1100011;
      endcase
      gen(w, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom,
          $urandom, $urandom, n);
   endtask

   task automatic drive(input cyc_t r);
      bus.imem_ack   = r.imem_ack;
      bus.imem_rdata = r.imem_rdata;
      bus.dmem_ack   = r.dmem_ack;
      bus.dmem_rdata = r.dmem_rdata;
      alu_result     = r.alu_result;
      imm            = r.imm;
      rs2_data       = r.rs2_data;
   endtask

   task automatic compare(input cyc_t r);
      chk("imem_req", 32'(bus.imem_req), 32'(r.e_imem_req));
      chk("imem_addr", bus.imem_addr, r.e_pc);
      chk("pc", pc, r.e_pc);
      chk("retired", retired, r.e_retired);
      chk("ir", ir, r.e_ir);
      chk("dmem_req", 32'(bus.dmem_req), 32'(r.e_dmem_req));
      chk("dmem_we", 32'(bus.dmem_we), 32'(r.e_dmem_we));
      chk("rf_we", 32'(rf_we), 32'(r.e_rf_we));
      chk("halted", 32'(halted), 32'(r.e_halted));
      chk("illegal", 32'(illegal), 32'(r.e_illegal));
      chk("bus_err", 32'(bus_err), 32'h0);
      if (r.e_dmem_req) begin
         chk("dmem_addr", bus.dmem_addr, r.e_dmem_addr);
         chk("dmem_wdata", bus.dmem_wdata, r.e_dmem_wdata);
      end
      if (r.e_rf_we) chk("rf_wdata", rf_wdata, r.e_rf_wdata);
      if (rf_we) begin
         rf_we_cnt++;
         last_wdata = rf_wdata;
      end
   endtask

   // Each cycle starts just after a negedge: drive inputs, then check outputs.
   task automatic run_queue();
      cyc_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         drive(r);
         #1;
         compare(r);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      bus.imem_ack   = 1'b0;
      bus.dmem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.dmem_rdata = 32'h0;
      alu_result     = 32'h0;
      imm            = 32'h0;
      rs2_data       = 32'h0;
      @(negedge clk);
      rst       = 1'b1;
      m_pc      = 32'h0;
      m_ret     = 32'h0;
      m_ir      = 32'h0;
      m_halted  = 1'b0;
      m_illegal = 1'b0;
      rf_we_cnt = 0;
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_retired", retired, 32'h0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_imem_req", 32'(bus.imem_req), 32'h1);
      chk("rst_dmem_req", 32'(bus.dmem_req), 32'h0);
      chk("rst_rf_we", 32'(rf_we), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b0;
      @(negedge clk);

      // Directed program: addi, ALU ops, taken/not-taken branch, slow load, store, ecall.
      do_reset();
      gen(32'h0050_0093, 0, 0, 32'd5, $urandom, $urandom, $urandom, n);
      chk("addi_latency", n, 4);
      run_queue();
      #1;
      chk("addi_pc", pc, 32'd4);
      chk("addi_retired", retired, 32'd1);
      chk("addi_rf_we_count", rf_we_cnt, 1);
      chk("addi_rf_wdata", last_wdata, 32'd5);
      for (int i = 0; i < 3; i++) gen_rand_alu();
      gen(32'hFE00_0CE3, 0, 0, 32'd1, 32'hFFFF_FFF8, $urandom, $urandom, n);
      chk("branch_latency", n, 3);
      run_queue();
      #1;
      chk("branch_taken_pc", pc, 32'd8);
      chk("branch_rf_we_count", rf_we_cnt, 4);
      for (int i = 0; i < 2; i++) gen_rand_alu();
      gen(32'hFE00_0CE3, 1, 0, 32'd0, 32'hFFFF_FFF8, $urandom, $urandom, n);
      run_queue();
      #1;
      chk("branch_not_taken_pc", pc, 32'd20);
      gen(32'h0000_2103, 0, 3, 32'h0000_0040, $urandom, 32'hCAFE_F00D, $urandom, n);
      chk("load_latency", n, 8);
      gen(32'h0020_2023, 0, 0, 32'h0000_0044, $urandom, $urandom, 32'h1234_5678, n);
      chk("store_latency", n, 4);
      run_queue();
      #1;
      chk("load_rf_wdata", last_wdata, 32'hCAFE_F00D);
      chk("store_pc", pc, 32'd28);
      chk("program_retired", retired, 32'd10);
      gen(32'h0000_0073, 0, 0, $urandom, $urandom, $urandom, $urandom, n);
      run_queue();
      #1;
      chk("ecall_halted", 32'(halted), 32'h1);
      chk("ecall_illegal", 32'(illegal), 32'h0);
      chk("ecall_imem_req", 32'(bus.imem_req), 32'h0);
      chk("ecall_pc_frozen", pc, 32'd28);

      // Unsupported opcode.
      do_reset();
      gen(32'h0000_007F, 0, 0, $urandom, $urandom, $urandom, $urandom, n);
      run_queue();
      #1;
      chk("illegal_halted", 32'(halted), 32'h1);
      chk("illegal_flag", 32'(illegal), 32'h1);

      // PC wrap through 0xFFFF_FFFC, then a randomized program ending in ecall.
      do_reset();
      gen(32'h0000_0063, 0, 0, 32'd1, 32'hFFFF_FFFC, $urandom, $urandom, n);
      gen_rand_alu();
      run_queue();
      #1;
      chk("pc_wrap", pc, 32'h0);
      chk("pc_wrap_retired", retired, 32'd2);
      for (int i = 0; i < 80; i++) gen_rand();
      gen(32'h0000_0073, $urandom_range(0, 2), 0, $urandom, $urandom, $urandom, $urandom, n);
      run_queue();

      // Reset while a store is waiting in MEM; a late dmem_ack must do nothing.
      do_reset();
      gen_rand_alu();
      gen_rand_alu();
      n = q.size();
      gen(32'h0020_2023, 0, 6, 32'h0000_0080, $urandom, $urandom, $urandom, n);
      while (q.size() > n + 5) void'(q.pop_back());
      run_queue();
      #1;
      chk("mid_mem_dmem_req", 32'(bus.dmem_req), 32'h1);
      chk("mid_mem_retired", retired, 32'd2);
      do_reset();
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      #1;
      chk("late_ack_imem_req", 32'(bus.imem_req), 32'h1);
      chk("late_ack_dmem_req", 32'(bus.dmem_req), 32'h0);
      chk("late_ack_rf_we", 32'(rf_we), 32'h0);
      chk("late_ack_pc", pc, 32'h0);
      chk("late_ack_ir", ir, 32'h0);

      // Fetch that is never acknowledged.
      do_reset();
`ifdef SEQ_MEM_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("to_wait_imem_req", 32'(bus.imem_req), 32'h1);
         chk("to_wait_bus_err", 32'(bus_err), 32'h0);
         @(negedge clk);
      end
      #1;
      chk("to_bus_err", 32'(bus_err), 32'h1);
      chk("to_halted", 32'(halted), 32'h1);
      chk("to_imem_req", 32'(bus.imem_req), 32'h0);
      chk("to_illegal", 32'(illegal), 32'h0);
`else
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("nto_imem_req", 32'(bus.imem_req), 32'h1);
         chk("nto_bus_err", 32'(bus_err), 32'h0);
         chk("nto_halted", 32'(halted), 32'h0);
         @(negedge clk);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
